// File: rtl/async_fifo_write_arbiter.sv
// async_fifo_write_arbiter
//   Round-robin arbiter that merges NUM_REQ ready/valid requesters into the
//   write port of an asynchronous FIFO (write-clock domain). A requester is
//   granted for a burst of up to MAX_BURST beats. Every burst is followed by
//   one IDLE cycle, which also serves as the arbitration cycle.
// Ports:
//   clk, rst        write-side clock, asynchronous active-high reset
//   req_valid       per-requester beat offer
//   req_data        requester i data at [i*BITS +: BITS]
//   req_ready       per-requester accept (only the owner, only when not full)
//   p_write_full    FIFO full flag (stalls the burst)
//   p_write_en      FIFO write strobe
//   p_write_data    FIFO write data (0 in IDLE)
//   p_grant_id      owner in GRANT, last owner in IDLE
//   p_grant_active  1 while in GRANT
//   p_beats_total   accepted beat count, wraps modulo 2^16
module async_fifo_write_arbiter #(
  parameter int BITS      = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      p_write_full,
  output logic                      p_write_en,
  output logic [BITS-1:0]           p_write_data,
  output logic [$clog2(NUM_REQ)-1:0] p_grant_id,
  output logic                      p_grant_active,
  output logic [15:0]               p_beats_total
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [IW-1:0] LAST_ID  = IW'(NUM_REQ - 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   owner, last_owner, sel_id;
  logic [BW-1:0]   beat_cnt;
  logic [15:0]     beats_total;
  logic            owner_valid;
  logic [BITS-1:0] owner_data;
  logic            accept;

  // Round-robin pick: lowest valid index above last_owner wins; otherwise
  // wrap to the lowest valid index at or below it. Loops run descending so
  // the final assignment is the smallest matching index in each pass.
  always_comb begin
    sel_id = last_owner;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req_valid[i-1] && (IW'(i-1) <= last_owner)) sel_id = IW'(i-1);
    end
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (req_valid[i-1] && (IW'(i-1) > last_owner)) sel_id = IW'(i-1);
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner == IW'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*BITS +: BITS];
      end
    end
  end

  assign accept = (state == GRANT) && !p_write_full && owner_valid;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= LAST_ID;
      last_owner  <= LAST_ID;
      beat_cnt    <= '0;
      beats_total <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (|req_valid) begin
          owner    <= sel_id;
          beat_cnt <= '0;
        end
      end else begin
        if (accept) beat_cnt <= beat_cnt + BW'(1);
        if (state_nxt == IDLE) last_owner <= owner;
      end
      if (accept) beats_total <= beats_total + 16'd1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req_valid) state_nxt = GRANT;
      GRANT:   if ((accept && (beat_cnt == BEAT_MAX)) || !owner_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready = '0;
    if ((state == GRANT) && !p_write_full) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (owner == IW'(i));
      end
    end
    p_write_en     = accept;
    p_write_data   = (state == GRANT) ? owner_data : '0;
    p_grant_id     = (state == GRANT) ? owner : last_owner;
    p_grant_active = (state == GRANT);
    p_beats_total  = beats_total;
  end

endmodule

// File: tb/tb_async_fifo_write_arbiter.sv
// Directed testbench for async_fifo_write_arbiter (BITS=32, NUM_REQ=4,
// MAX_BURST=4). A small requester model holds, per requester, a count of
// beats remaining and the next data value; it advances on valid & ready.
module tb_async_fifo_write_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         p_write_full;
  logic         p_write_en;
  logic [31:0]  p_write_data;
  logic [1:0]   p_grant_id;
  logic         p_grant_active;
  logic [15:0]  p_beats_total;

  async_fifo_write_arbiter #(
    .BITS(32),
    .NUM_REQ(4),
    .MAX_BURST(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .p_write_full(p_write_full),
    .p_write_en(p_write_en),
    .p_write_data(p_write_data),
    .p_grant_id(p_grant_id),
    .p_grant_active(p_grant_active),
    .p_beats_total(p_beats_total)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int          cnt [4];
  logic [31:0] nxt [4];

  logic        o_en, o_active;
  logic [31:0] o_data;
  logic [1:0]  o_id;
  logic [3:0]  o_ready;

  logic [31:0] log_data [$];
  logic [1:0]  log_id [$];
  bit          en_trace [$];
  int          runs [$];
  int          gaps [$];

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (cnt[i] > 0);
      req_data[i*32 +: 32] = nxt[i];
    end
  endtask

  // One clock: observe at negedge, then advance the requester model after
  // the posedge and re-drive inputs.
  task automatic step();
    @(negedge clk);
    o_en = p_write_en; o_active = p_grant_active; o_data = p_write_data;
    o_id = p_grant_id; o_ready = req_ready;
    en_trace.push_back(o_en);
    if (o_en) begin
      log_data.push_back(o_data);
      log_id.push_back(o_id);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && o_ready[i]) begin
        cnt[i]--;
        nxt[i]++;
      end
    end
    apply();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    p_write_full = 1'b0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; nxt[i] = '0; end
    apply();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    log_data.delete(); log_id.delete(); en_trace.delete();
  endtask

  task automatic build_runs();
    int len, gap;
    bit seen;
    runs.delete(); gaps.delete();
    len = 0; gap = 0; seen = 0;
    foreach (en_trace[k]) begin
      if (en_trace[k]) begin
        if (len == 0 && seen) gaps.push_back(gap);
        len++; gap = 0;
      end else begin
        if (len > 0) begin runs.push_back(len); seen = 1; end
        len = 0; gap++;
      end
    end
    if (len > 0) runs.push_back(len);
  endtask

  task automatic test_reset();
    int en_seen;
    rst = 1'b1;
    p_write_full = 1'b0;
    for (int i = 0; i < 4; i++) begin cnt[i] = 0; nxt[i] = '0; end
    apply();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests++;
      if ({p_write_en, p_grant_active, req_ready, p_grant_id} !== {1'b0, 1'b0, 4'h0, 2'd3}) begin
        fails++;
        $display("FAIL reset_ctrl cyc=%0d got en=%b act=%b rdy=%b id=%0d exp en=0 act=0 rdy=0000 id=3",
                 c, p_write_en, p_grant_active, req_ready, p_grant_id);
      end
      tests++;
      if ({p_write_data, p_beats_total} !== 48'h0) begin
        fails++;
        $display("FAIL reset_data cyc=%0d got data=%h total=%0d exp 0/0", c, p_write_data, p_beats_total);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    en_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (p_write_en) en_seen++;
      tests++;
      if ({p_grant_active, req_ready, p_grant_id, p_write_data, p_beats_total} !==
          {1'b0, 4'h0, 2'd3, 32'h0, 16'h0}) begin
        fails++;
        $display("FAIL idle_outputs cyc=%0d got act=%b rdy=%b id=%0d data=%h total=%0d exp 0/0000/3/0/0",
                 c, p_grant_active, req_ready, p_grant_id, p_write_data, p_beats_total);
      end
    end
    tests++;
    if (en_seen !== 0) begin
      fails++;
      $display("FAIL idle_no_write got %0d write cycles exp 0", en_seen);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    do_reset();
    cnt[2] = 10; nxt[2] = 32'h100;
    apply();
    repeat (25) step();
    build_runs();
    tests++;
    if (en_trace[0] !== 1'b0 || en_trace[1] !== 1'b1) begin
      fails++;
      $display("FAIL single_latency got en[0]=%b en[1]=%b exp 0 1", en_trace[0], en_trace[1]);
    end
    tests++;
    if (runs.size() !== 3 || gaps.size() !== 2) begin
      fails++;
      $display("FAIL single_bursts got %0d bursts %0d gaps exp 3 2", runs.size(), gaps.size());
    end else begin
      tests++;
      if (runs[0] !== 4 || runs[1] !== 4 || runs[2] !== 2) begin
        fails++;
        $display("FAIL single_lengths got %0d,%0d,%0d exp 4,4,2", runs[0], runs[1], runs[2]);
      end
      tests++;
      if (gaps[0] !== 1 || gaps[1] !== 1) begin
        fails++;
        $display("FAIL single_gaps got %0d,%0d exp 1,1", gaps[0], gaps[1]);
      end
    end
    tests++;
    if (log_data.size() !== 10) begin
      fails++;
      $display("FAIL single_count got %0d writes exp 10", log_data.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        tests++;
        if (log_data[k] !== 32'h100 + k || log_id[k] !== 2'd2) begin
          fails++;
          $display("FAIL single_data k=%0d got %h id=%0d exp %h id=2", k, log_data[k], log_id[k], 32'h100 + k);
        end
      end
    end
    tests++;
    if (p_beats_total !== 16'd10) begin
      fails++;
      $display("FAIL single_total got %0d exp 10", p_beats_total);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  eid;
    logic [31:0] edata;
    do_reset();
    for (int i = 0; i < 4; i++) begin cnt[i] = 8; nxt[i] = 32'(i) << 12; end
    apply();
    repeat (50) step();
    build_runs();
    tests++;
    if (runs.size() !== 8) begin
      fails++;
      $display("FAIL rr_bursts got %0d bursts exp 8", runs.size());
    end else begin
      foreach (runs[b]) begin
        tests++;
        if (runs[b] !== 4) begin
          fails++;
          $display("FAIL rr_len b=%0d got %0d exp 4", b, runs[b]);
        end
      end
    end
    tests++;
    if (log_data.size() !== 32) begin
      fails++;
      $display("FAIL rr_count got %0d writes exp 32", log_data.size());
    end else begin
      for (int j = 0; j < 32; j++) begin
        eid   = 2'((j / 4) % 4);
        edata = (32'(eid) << 12) + 32'((j / 16) * 4 + (j % 4));
        tests++;
        if (log_id[j] !== eid || log_data[j] !== edata) begin
          fails++;
          $display("FAIL rr_beat j=%0d got id=%0d data=%h exp id=%0d data=%h", j, log_id[j], log_data[j], eid, edata);
        end
      end
    end
    tests++;
    if (p_beats_total !== 16'd32) begin
      fails++;
      $display("FAIL rr_total got %0d exp 32", p_beats_total);
    end
  endtask

  task automatic test_full_stall();
    int bad;
    do_reset();
    cnt[1] = 8; nxt[1] = 32'h200;
    apply();
    step(); step(); step();
    tests++;
    if (o_en !== 1'b1 || o_data !== 32'h201) begin
      fails++;
      $display("FAIL stall_pre got en=%b data=%h exp 1 00000201", o_en, o_data);
    end
    p_write_full = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (o_en !== 1'b0 || o_ready !== 4'h0 || o_active !== 1'b1 || o_id !== 2'd1) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL stall_hold got %0d bad cycles exp 0", bad);
    end
    p_write_full = 1'b0;
    step();
    tests++;
    if (o_en !== 1'b1 || o_data !== 32'h202) begin
      fails++;
      $display("FAIL stall_beat3 got en=%b data=%h exp 1 00000202", o_en, o_data);
    end
    step();
    tests++;
    if (o_en !== 1'b1 || o_data !== 32'h203) begin
      fails++;
      $display("FAIL stall_beat4 got en=%b data=%h exp 1 00000203", o_en, o_data);
    end
    step();
    tests++;
    if (o_active !== 1'b0 || o_en !== 1'b0 || o_id !== 2'd1) begin
      fails++;
      $display("FAIL stall_release got act=%b en=%b id=%0d exp 0 0 1", o_active, o_en, o_id);
    end
    tests++;
    if (p_beats_total !== 16'd4) begin
      fails++;
      $display("FAIL stall_total got %0d exp 4", p_beats_total);
    end
  endtask

  task automatic test_valid_drop();
    do_reset();
    cnt[3] = 1; nxt[3] = 32'h300;
    apply();
    step();
    cnt[0] = 2; nxt[0] = 32'h400;
    apply();
    step();
    tests++;
    if (o_active !== 1'b1 || o_id !== 2'd3 || o_en !== 1'b1 || o_data !== 32'h300) begin
      fails++;
      $display("FAIL drop_beat got act=%b id=%0d en=%b data=%h exp 1 3 1 00000300", o_active, o_id, o_en, o_data);
    end
    step();
    tests++;
    if (o_active !== 1'b1 || o_en !== 1'b0) begin
      fails++;
      $display("FAIL drop_cycle got act=%b en=%b exp 1 0", o_active, o_en);
    end
    step();
    tests++;
    if (o_active !== 1'b0 || o_id !== 2'd3) begin
      fails++;
      $display("FAIL drop_bubble got act=%b id=%0d exp 0 3", o_active, o_id);
    end
    step();
    tests++;
    if (o_active !== 1'b1 || o_id !== 2'd0 || o_data !== 32'h400) begin
      fails++;
      $display("FAIL drop_regrant got act=%b id=%0d data=%h exp 1 0 00000400", o_active, o_id, o_data);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    cnt[2] = 8; nxt[2] = 32'h500;
    apply();
    step(); step();
    tests++;
    if (o_en !== 1'b1 || p_beats_total !== 16'd1) begin
      fails++;
      $display("FAIL midrst_pre got en=%b total=%0d exp 1 1", o_en, p_beats_total);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({p_write_en, p_grant_active, req_ready, p_grant_id, p_write_data, p_beats_total} !==
        {1'b0, 1'b0, 4'h0, 2'd3, 32'h0, 16'h0}) begin
      fails++;
      $display("FAIL midrst_async got en=%b act=%b rdy=%b id=%0d data=%h total=%0d exp 0/0/0000/3/0/0",
               p_write_en, p_grant_active, req_ready, p_grant_id, p_write_data, p_beats_total);
    end
    for (int i = 0; i < 4; i++) begin cnt[i] = 4; nxt[i] = (32'(i) << 12) | 32'h600; end
    apply();
    step();
    tests++;
    if (o_en !== 1'b0 || o_active !== 1'b0 || p_beats_total !== 16'd0) begin
      fails++;
      $display("FAIL midrst_hold got en=%b act=%b total=%0d exp 0 0 0", o_en, o_active, p_beats_total);
    end
    rst = 1'b0;
    step();
    tests++;
    if (o_active !== 1'b0) begin
      fails++;
      $display("FAIL midrst_arb got act=%b exp 0", o_active);
    end
    step();
    tests++;
    if (o_active !== 1'b1 || o_id !== 2'd0 || o_en !== 1'b1) begin
      fails++;
      $display("FAIL midrst_first got act=%b id=%0d en=%b exp 1 0 1", o_active, o_id, o_en);
    end
  endtask

  initial begin
    req_valid = '0;
    req_data  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_valid_drop();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
